// File: rtl/baud_pkg.sv
// baud_pkg: shared constants and helpers for the fractional-N baud generator.
//   ACC_W_DEF       default phase-accumulator width
//   OVERSAMPLE_DEF  default oversample ticks per bit
//   baud_inc()      phase increment for a given clock, baud rate and oversample
//                   factor, used to build the register-file reset value of inc.
package baud_pkg;

    localparam int ACC_W_DEF      = 16;
    localparam int OVERSAMPLE_DEF = 8;

    // round(baud * os * 2^acc_w / f_clk), evaluated in 64-bit unsigned arithmetic.
    function automatic longint unsigned baud_inc(
        input longint unsigned f_clk,
        input longint unsigned baud,
        input longint unsigned os,
        input int unsigned     acc_w
    );
        longint unsigned num;
        num = baud * os * (64'd1 << acc_w);
        return (num + f_clk / 2) / f_clk;
    endfunction

endpackage

// File: rtl/baud_gen_frac_acc.sv
// baud_phase_acc: phase accumulator of the fractional-N baud generator.
//   clk    sole clock, posedge
//   rst    synchronous active-high reset, clears the accumulator
//   clr    synchronous clear (generator disabled or bit phase restarted)
//   inc    phase increment added every cycle
//   carry  carry-out of the add in progress (acc + inc >= 2^ACC_W); the parent
//          registers it into its tick flops on the same edge that wraps acc,
//          so a tick is visible in the cycle right after the producing edge.
module baud_phase_acc #(
    parameter int ACC_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [ACC_W-1:0] inc,
    output logic             carry
);

    logic [ACC_W-1:0] acc_reg;
    logic [ACC_W:0]   sum;

    assign sum   = {1'b0, acc_reg} + {1'b0, inc};
    assign carry = sum[ACC_W];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc_reg <= '0;
        end else begin
            // Wraps modulo 2^ACC_W; the dropped MSB is the carry.
            acc_reg <= sum[ACC_W-1:0];
        end
    end

endmodule

// File: rtl/baud_gen_frac.sv
// baud_gen_frac: fractional-N baud tick generator for the async UART.
// A phase accumulator yields an oversample tick at f_clk*inc/2^ACC_W; an
// oversample counter derives the bit tick and the mid-bit sample tick.
//   clk       sole clock, posedge
//   rst       synchronous active-high reset
//   enable    run; low holds the generator cleared
//   inc       phase increment (0 = no ticks); may change at any time
//   resync    restart bit phase (only when BAUD_GEN_RESYNC_EN is defined)
//   os_tick   one-cycle oversample tick
//   bit_tick  tick on the last oversample of each bit
//   mid_tick  tick on the bit-centre oversample
//   os_phase  oversample index within the bit, 0..OVERSAMPLE-1
// Build option: define BAUD_GEN_RESYNC_EN to add the resync port.
module baud_gen_frac
    import baud_pkg::*;
#(
    parameter int ACC_W      = ACC_W_DEF,
    parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [ACC_W-1:0]              inc,
`ifdef BAUD_GEN_RESYNC_EN
    input  logic                          resync,
`endif
    output logic                          os_tick,
    output logic                          bit_tick,
    output logic                          mid_tick,
    output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam logic [CNT_W-1:0] OS_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] OS_MID  = CNT_W'(OVERSAMPLE / 2 - 1);

    logic             clr;
    logic             carry;
    logic [CNT_W-1:0] os_cnt_reg;
    logic             os_tick_reg;
    logic             bit_tick_reg;
    logic             mid_tick_reg;

    // Disable and resync both restart the bit phase; a carry in that cycle is dropped.
`ifdef BAUD_GEN_RESYNC_EN
    assign clr = !enable || resync;
`else
    assign clr = !enable;
`endif

    baud_phase_acc #(
        .ACC_W (ACC_W)
    ) u_phase_acc (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .inc   (inc),
        .carry (carry)
    );

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            os_cnt_reg   <= '0;
            os_tick_reg  <= 1'b0;
            bit_tick_reg <= 1'b0;
            mid_tick_reg <= 1'b0;
        end else if (carry) begin
            os_tick_reg  <= 1'b1;
            bit_tick_reg <= (os_cnt_reg == OS_LAST);
            mid_tick_reg <= (os_cnt_reg == OS_MID);
            os_cnt_reg   <= (os_cnt_reg == OS_LAST) ? '0 : os_cnt_reg + 1'b1;
        end else begin
            os_tick_reg  <= 1'b0;
            bit_tick_reg <= 1'b0;
            mid_tick_reg <= 1'b0;
        end
    end

    assign os_tick  = os_tick_reg;
    assign bit_tick = bit_tick_reg;
    assign mid_tick = mid_tick_reg;
    assign os_phase = os_cnt_reg;

endmodule

// File: tb/tb_baud_gen_frac.sv
// tb_baud_gen_frac: self-checking bench for baud_gen_frac (ACC_W=16, OVERSAMPLE=8).
// A behavioural model counts carries with plain integer arithmetic and derives
// the expected ticks and phase from the running oversample-tick count.
module tb_baud_gen_frac;

    localparam int ACC_W = 16;
    localparam int OS    = 8;
    localparam int CNT_W = $clog2(OS);
    localparam longint MODV = longint'(1) << ACC_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             enable;
    logic [ACC_W-1:0] inc;
    logic             resync;
    logic             os_tick;
    logic             bit_tick;
    logic             mid_tick;
    logic [CNT_W-1:0] os_phase;

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;

    // reference model state
    longint m_acc;
    int     m_ticks;   // oversample ticks since last clear
    logic   exp_os, exp_bit, exp_mid;
    int     exp_phase;

    baud_gen_frac #(
        .ACC_W      (ACC_W),
        .OVERSAMPLE (OS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .inc      (inc),
`ifdef BAUD_GEN_RESYNC_EN
        .resync   (resync),
`endif
        .os_tick  (os_tick),
        .bit_tick (bit_tick),
        .mid_tick (mid_tick),
        .os_phase (os_phase)
    );

    always #5 clk = ~clk;

    task automatic check_value(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
        end
    endtask

    // Predict the outputs after the next rising edge from the inputs now applied.
    task automatic model_step();
        logic clear;
        longint s;
        clear = rst || !enable;
`ifdef BAUD_GEN_RESYNC_EN
        clear = clear || resync;
`endif
        exp_os  = 1'b0;
        exp_bit = 1'b0;
        exp_mid = 1'b0;
        if (clear) begin
            m_acc   = 0;
            m_ticks = 0;
        end else begin
            s = m_acc + longint'(inc);
            if (s >= MODV) begin
                m_ticks++;
                exp_os  = 1'b1;
                exp_bit = (m_ticks % OS) == 0;
                exp_mid = (m_ticks % OS) == OS / 2;
            end
            m_acc = s % MODV;
        end
        exp_phase = m_ticks % OS;
    endtask

    // One clock: model predicts, DUT outputs compared away from the edge.
    task automatic tick();
        model_step();
        @(negedge clk);
        cyc++;
        check_value("cyc", {os_tick, bit_tick, mid_tick, os_phase},
                    {exp_os, exp_bit, exp_mid, 3'(exp_phase)});
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; resync = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    // Edges from now until the next os_tick (bounded); -1 if no tick within the bound.
    task automatic edges_to_tick(output int n);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (os_tick && n < 0) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n, found, ticks, last, bad, r;

        rst = 1'b1; enable = 1'b0; inc = '0; resync = 1'b0;
        m_acc = 0; m_ticks = 0;

        // reset state
        do_reset();
        check_value("reset_outs", {os_tick, bit_tick, mid_tick, os_phase}, 0);
        $display("reset: outputs=%b%b%b phase=%0d", os_tick, bit_tick, mid_tick, os_phase);

        // inc=16384: os_tick every 4 cycles, first after edge 4, bit_tick every 32
        inc = 16'd16384; enable = 1'b1;
        edges_to_tick(n);
        check_value("first_os_edge", n, 4);
        ticks = 1; last = cyc; bad = 0;
        for (int i = 0; i < 64; i++) begin
            tick();
            if (os_tick) begin
                ticks++;
                if (cyc - last != 4) bad++;
                last = cyc;
                if (ticks == 4)  check_value("mid_on_4th", mid_tick, 1);
                if (ticks == 8)  check_value("bit_on_8th", bit_tick, 1);
                if (ticks == 16) check_value("bit_on_16th", bit_tick, 1);
            end
        end
        check_value("period4_gaps", bad, 0);
        $display("inc=16384: first tick after edge %0d, %0d ticks", n, ticks);

        // inc=0x5555 from a cleared accumulator: count and gap regularity
        do_reset();
        inc = 16'h5555; enable = 1'b1;
        ticks = 0; last = -1; bad = 0;
        for (int i = 0; i < 6000; i++) begin
            tick();
            if (os_tick) begin
                ticks++;
                if (last >= 0 && (cyc - last < 3 || cyc - last > 4)) bad++;
                last = cyc;
            end
        end
        check_value("frac_count", ticks, (6000 * 21845) / 65536);
        check_value("frac_gaps", bad, 0);
        $display("inc=0x5555: %0d ticks in 6000 cycles", ticks);

        // enable dropped for one cycle at os_phase=5
        do_reset();
        inc = 16'd16384; enable = 1'b1;
        found = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (os_phase == 3'd5) begin found = 1; break; end
        end
        check_value("wait_phase5", found, 1);
        enable = 1'b0;
        tick();
        check_value("dis_outs", {os_tick, bit_tick, mid_tick, os_phase}, 0);
        enable = 1'b1;
        edges_to_tick(n);
        check_value("reenable_edge", n, 4);
        $display("enable drop: next tick %0d edges after re-enable", n);

        // reset while bit_tick is high
        found = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (bit_tick) begin found = 1; break; end
        end
        check_value("wait_bit", found, 1);
        rst = 1'b1;
        tick();
        check_value("rst_bit_outs", {os_tick, bit_tick, mid_tick, os_phase}, 0);
        rst = 1'b0;
        edges_to_tick(n);
        check_value("rst_acc_clear", n, 4);
        rst = 1'b1; enable = 1'b0; resync = 1'b1;
        tick();
        check_value("rst_combo_outs", {os_tick, bit_tick, mid_tick, os_phase}, 0);
        rst = 1'b0; resync = 1'b0; enable = 1'b1;
        $display("reset during bit_tick: next tick %0d edges after release", n);

`ifdef BAUD_GEN_RESYNC_EN
        // resync coinciding with a carry suppresses that tick
        do_reset();
        inc = 16'd16384; enable = 1'b1;
        tick(); tick(); tick();
        resync = 1'b1;
        tick();
        check_value("resync_outs", {os_tick, bit_tick, mid_tick, os_phase}, 0);
        resync = 1'b0;
        edges_to_tick(n);
        check_value("resync_edge", n, 4);
        $display("resync: next tick %0d edges later", n);
`endif

        // inc 16384 -> 32768 mid-run: period 2 from the next add, phase continues
        do_reset();
        inc = 16'd16384; enable = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        inc = 16'd32768;
        ticks = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (os_tick) ticks++;
        end
        check_value("inc_switch_ticks", ticks, 4);
        $display("inc switch: %0d ticks in 8 cycles after change", ticks);

        // randomized run: inc changes, enable drops, occasional reset
        do_reset();
        enable = 1'b1; inc = 16'($urandom);
        for (int i = 0; i < 6000; i++) begin
            r = $urandom_range(0, 199);
            rst    = (r == 0);
            enable = (r > 3);
`ifdef BAUD_GEN_RESYNC_EN
            resync = (r == 4);
`endif
            if (r >= 5 && r < 9) begin
                case ($urandom_range(0, 4))
                    0: inc = 16'd0;
                    1: inc = 16'hFFFF;
                    2: inc = 16'h8000;
                    3: inc = 16'($urandom_range(1, 4096));
                    default: inc = 16'($urandom);
                endcase
            end
            tick();
        end
        rst = 1'b0; resync = 1'b0;
        $display("random run: %0d cycles", 6000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
